speaker_tone_gen: RTL and testbench



---
 rtl/speaker_tone_pkg.sv | 34 +++
 rtl/speaker_tone_channel.sv | 77 +++++++
 rtl/speaker_tone_gen.sv | 142 ++++++++++++++
 tb/tb_speaker_tone_gen.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/speaker_tone_pkg.sv
// speaker_tone_pkg: register map, CONTROL bit positions and channel state
// encoding shared by the speaker tone generator and its channel sub-module.
package speaker_tone_pkg;

   localparam int unsigned ADDR_W       = 4;

   localparam int unsigned ADDR_CONTROL = 0;
   localparam int unsigned ADDR_STATUS  = 1;
   localparam int unsigned ADDR_LEGACY  = 2;
   localparam int unsigned ADDR_IRQ     = 3;
   localparam int unsigned ADDR_CH_BASE = 4;

   localparam int unsigned CTRL_ENABLE  = 0;
   localparam int unsigned CTRL_LEGACY  = 1;

   localparam int unsigned IRQ_MASK_LSB = 0;
   localparam int unsigned IRQ_PEND_LSB = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } ch_state_e;

   // Word address of channel n's DIVIDER register
   function automatic logic [ADDR_W-1:0] div_addr(input int n);
      return ADDR_W'(ADDR_CH_BASE + 2 * n);
   endfunction

   // Word address of channel n's DURATION register
   function automatic logic [ADDR_W-1:0] dur_addr(input int n);
      return ADDR_W'(ADDR_CH_BASE + 2 * n + 1);
   endfunction

endpackage

// File: rtl/speaker_tone_channel.sv
// speaker_tone_channel: one square-wave voice. Half-period counter reloads
// from the live divider value; duration counts down on the shared ms tick.
module speaker_tone_channel
   import speaker_tone_pkg::*;
#(
   parameter int unsigned DIV_WIDTH = 24,
   parameter int unsigned DUR_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 tick_i,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic [DUR_WIDTH-1:0] dur_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   output logic                 tone_o,
   output logic                 busy_o,
   output logic                 done_c,
   output logic [DUR_WIDTH-1:0] remain_o
);

   ch_state_e            state_q;
   logic [DIV_WIDTH-1:0] halfcnt_q;
   logic [DUR_WIDTH-1:0] remain_q;
   logic                 wave_q;
   logic                 last_tick;

   // Final tick of a timed note; bus writes on the same edge take priority
   assign last_tick = (state_q == ST_PLAY) && tick_i && !start_i && !stop_i &&
                      (remain_q == DUR_WIDTH'(1));

   // Channel FSM with half-period and duration counters
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         halfcnt_q <= '0;
         remain_q  <= '0;
         wave_q    <= 1'b0;
      end else if (stop_i) begin
         state_q   <= ST_IDLE;
         halfcnt_q <= '0;
         remain_q  <= '0;
         wave_q    <= 1'b0;
      end else if (start_i) begin
         state_q   <= ST_PLAY;
         halfcnt_q <= div_i - DIV_WIDTH'(1);
         remain_q  <= dur_i;
         wave_q    <= 1'b0;
      end else if (state_q == ST_PLAY) begin
         if (last_tick) begin
            state_q   <= ST_IDLE;
            halfcnt_q <= '0;
            remain_q  <= '0;
            wave_q    <= 1'b0;
         end else begin
            if (tick_i && (remain_q != '1)) begin
               remain_q <= remain_q - DUR_WIDTH'(1);
            end
            if (div_i == '0) begin
               wave_q    <= 1'b0;
               halfcnt_q <= '0;
            end else if (halfcnt_q == '0) begin
               wave_q    <= ~wave_q;
               halfcnt_q <= div_i - DIV_WIDTH'(1);
            end else begin
               halfcnt_q <= halfcnt_q - DIV_WIDTH'(1);
            end
         end
      end
   end

   assign tone_o   = wave_q;
   assign busy_o   = (state_q == ST_PLAY);
   assign done_c   = last_tick;
   assign remain_o = remain_q;

endmodule

// File: rtl/speaker_tone_gen.sv
// speaker_tone_gen: Avalon-MM multi-channel square-wave tone generator with a
// legacy single-bit speaker mode. Optional interrupt logic is built when the
// macro SPEAKER_TONE_IRQ_EN is defined.
module speaker_tone_gen
   import speaker_tone_pkg::*;
#(
   parameter int unsigned CHANNELS  = 2,
   parameter int unsigned DIV_WIDTH = 24,
   parameter int unsigned DUR_WIDTH = 16,
   parameter int unsigned PRESCALE  = 50000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   address,
   input  logic                chipselect,
   input  logic                write_n,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   output logic [CHANNELS-1:0] tone_out,
   output logic                speaker_out
`ifdef SPEAKER_TONE_IRQ_EN
   ,
   output logic                irq
`endif
);

   localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic                 wr;
   logic                 ctrl_off;
   logic                 dur_nz;
   logic [1:0]           ctrl_q;
   logic                 legacy_q;
   logic [DIV_WIDTH-1:0] div_q [CHANNELS];
   logic [PS_W-1:0]      ps_q;
   logic [PS_W-1:0]      ps_d;
   logic                 tick;
   logic [CHANNELS-1:0]  busy;
   logic [CHANNELS-1:0]  tone;
   logic [CHANNELS-1:0]  done;
   logic [DUR_WIDTH-1:0] remain [CHANNELS];
   logic                 unused_bits;

   assign wr       = chipselect && !write_n;
   assign ctrl_off = wr && (address == ADDR_W'(ADDR_CONTROL)) && !writedata[CTRL_ENABLE];
   assign dur_nz   = |writedata[DUR_WIDTH-1:0];

   // Free-running millisecond prescaler shared by all channels
   assign tick = (ps_q == PS_W'(PRESCALE - 1));
   assign ps_d = tick ? '0 : ps_q + PS_W'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ps_q <= '0;
      else          ps_q <= ps_d;
   end

   // CONTROL, LEGACY_DATA and DIVIDER registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q   <= '0;
         legacy_q <= 1'b0;
         for (int n = 0; n < CHANNELS; n++) div_q[n] <= '0;
      end else if (wr) begin
         if (address == ADDR_W'(ADDR_CONTROL)) ctrl_q   <= writedata[1:0];
         if (address == ADDR_W'(ADDR_LEGACY))  legacy_q <= writedata[0];
         for (int n = 0; n < CHANNELS; n++) begin
            if (address == div_addr(n)) div_q[n] <= writedata[DIV_WIDTH-1:0];
         end
      end
   end

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      logic dur_hit;
      assign dur_hit = wr && (address == dur_addr(n));

      speaker_tone_channel #(
         .DIV_WIDTH (DIV_WIDTH),
         .DUR_WIDTH (DUR_WIDTH)
      ) u_ch (
         .clk_i    (clk),
         .rst_ni   (reset_n),
         .tick_i   (tick),
         .start_i  (dur_hit && dur_nz && ctrl_q[CTRL_ENABLE]),
         .stop_i   ((dur_hit && !dur_nz) || ctrl_off),
         .dur_i    (writedata[DUR_WIDTH-1:0]),
         .div_i    (div_q[n]),
         .tone_o   (tone[n]),
         .busy_o   (busy[n]),
         .done_c   (done[n]),
         .remain_o (remain[n])
      );
   end

   assign tone_out    = tone;
   assign speaker_out = ctrl_q[CTRL_LEGACY] ? legacy_q : (ctrl_q[CTRL_ENABLE] & (|tone));

`ifdef SPEAKER_TONE_IRQ_EN
   logic                irq_wr;
   logic [CHANNELS-1:0] mask_q;
   logic [CHANNELS-1:0] pend_q;
   logic [CHANNELS-1:0] pend_clr;
   logic                irq_q;

   assign irq_wr   = wr && (address == ADDR_W'(ADDR_IRQ));
   assign pend_clr = irq_wr ? writedata[IRQ_PEND_LSB +: CHANNELS] : '0;

   // Sticky end-of-note flags; a new completion beats a same-cycle clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q <= '0;
         pend_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         if (irq_wr) mask_q <= writedata[IRQ_MASK_LSB +: CHANNELS];
         pend_q <= (pend_q & ~pend_clr) | done;
         irq_q  <= |(pend_q & mask_q);
      end
   end

   assign irq         = irq_q;
   assign unused_bits = ^writedata;
`else
   assign unused_bits = ^{writedata, done};
`endif

   // Zero-wait-state read mux; unmapped words read 0
   always_comb begin
      readdata = '0;
      if (address == ADDR_W'(ADDR_CONTROL)) readdata = 32'(ctrl_q);
      if (address == ADDR_W'(ADDR_STATUS))  readdata = 32'(busy);
      if (address == ADDR_W'(ADDR_LEGACY))  readdata = 32'(legacy_q);
`ifdef SPEAKER_TONE_IRQ_EN
      if (address == ADDR_W'(ADDR_IRQ))
         readdata = (32'(mask_q) << IRQ_MASK_LSB) | (32'(pend_q) << IRQ_PEND_LSB);
`endif
      for (int n = 0; n < CHANNELS; n++) begin
         if (address == div_addr(n)) readdata = 32'(div_q[n]);
         if (address == dur_addr(n)) readdata = 32'(remain[n]);
      end
   end

endmodule

// File: tb/tb_speaker_tone_gen.sv
// tb_speaker_tone_gen: directed stimulus pushes expected values into a
// scoreboard queue; a negedge monitor pops and compares against the DUT.
module tb_speaker_tone_gen;

   localparam int unsigned CH = 2;

   localparam int K_RD   = 0;
   localparam int K_TONE = 1;
   localparam int K_SPK  = 2;
   localparam int K_IRQ  = 3;
   localparam int K_MEAS = 4;

   logic          clk;
   logic          reset_n;
   logic [3:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [CH-1:0] tone_out;
   logic          speaker_out;
`ifdef SPEAKER_TONE_IRQ_EN
   logic          irq;
`endif

   speaker_tone_gen #(
      .CHANNELS  (CH),
      .DIV_WIDTH (24),
      .DUR_WIDTH (16),
      .PRESCALE  (10)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .tone_out    (tone_out),
      .speaker_out (speaker_out)
`ifdef SPEAKER_TONE_IRQ_EN
      ,
      .irq         (irq)
`endif
   );

   typedef struct {
      int          kind;
      logic [31:0] lo;
      logic [31:0] hi;
      logic [31:0] act;
      string       name;
   } chk_t;

   chk_t        sb_q[$];
   chk_t        cur;
   logic [31:0] got;
   int          n_checks = 0;
   int          n_errors = 0;
   int          idle_at;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void expect_sig(input int kind, input logic [31:0] val, input string name);
      chk_t e;
      e.kind = kind; e.lo = val; e.hi = val; e.act = '0; e.name = name;
      sb_q.push_back(e);
   endfunction

   function automatic void expect_range(input logic [31:0] act, input logic [31:0] lo,
                                        input logic [31:0] hi, input string name);
      chk_t e;
      e.kind = K_MEAS; e.lo = lo; e.hi = hi; e.act = act; e.name = name;
      sb_q.push_back(e);
   endfunction

   // Monitor: drain every pending expectation against the settled outputs
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         cur = sb_q.pop_front();
         case (cur.kind)
            K_RD:    got = readdata;
            K_TONE:  got = 32'(tone_out);
            K_SPK:   got = 32'(speaker_out);
`ifdef SPEAKER_TONE_IRQ_EN
            K_IRQ:   got = 32'(irq);
`endif
            default: got = cur.act;
         endcase
         n_checks++;
         if (((got >= cur.lo) && (got <= cur.hi)) !== 1'b1) begin
            n_errors++;
            if (cur.lo == cur.hi)
               $display("FAIL %s: got 0x%0h, required 0x%0h", cur.name, got, cur.lo);
            else
               $display("FAIL %s: got %0d, required %0d..%0d", cur.name, got, cur.lo, cur.hi);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic check_rd(input logic [3:0] a, input logic [31:0] v, input string name);
      address = a;
      expect_sig(K_RD, v, name);
      step(1);
   endtask

   // Poll STATUS until the masked busy bits clear; 0 means never within budget
   task automatic wait_idle(input logic [31:0] bits, input int budget, output int at);
      at = 0;
      for (int k = 1; k <= budget; k++) begin
         step(1);
         address = 4'd1;
         #1;
         if ((readdata & bits) === 32'd0) begin
            at = k;
            break;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;

      // Reset state
      step(2);
      expect_sig(K_TONE, 0, "rst_tone");
      expect_sig(K_SPK, 0, "rst_spk");
`ifdef SPEAKER_TONE_IRQ_EN
      expect_sig(K_IRQ, 0, "rst_irq");
`endif
      check_rd(4'd0, 0, "rst_control");
      reset_n = 1'b1;
      check_rd(4'd1, 0, "rst_status");
      check_rd(4'd5, 0, "rst_duration0");
      check_rd(4'd4, 0, "rst_divider0");

      // Register access, width masking and unmapped addresses
      bus_write(4'd4, 32'hFFFF_FFFF);
      check_rd(4'd4, 32'h00FF_FFFF, "div0_width_mask");
      bus_write(4'd4, 32'd3);
      bus_write(4'd0, 32'd1);
      check_rd(4'd0, 32'd1, "control_rd");
      bus_write(4'd8, 32'd7);
      check_rd(4'd8, 32'd0, "div_beyond_channels");
      bus_write(4'd9, 32'd5);
      check_rd(4'd1, 32'd0, "dur_beyond_channels_ignored");
      bus_write(4'd2, 32'hFFFF_FFFF);
      check_rd(4'd2, 32'd1, "legacy_rd_bit0");
      bus_write(4'd2, 32'd0);
`ifndef SPEAKER_TONE_IRQ_EN
      bus_write(4'd3, 32'hFFFF_FFFF);
      check_rd(4'd3, 32'd0, "irq_addr_unmapped");
`endif

      // Timed note on channel 0: half period 3 clk, 4 ticks of 10 clk
      bus_write(4'd5, 32'd4);
      address = 4'd5;
      expect_sig(K_RD, 32'd4, "t1_remain_start");
      expect_sig(K_TONE, 32'd0, "t1_tone_k0");
      idle_at = 0;
      for (int k = 1; k <= 60; k++) begin
         step(1);
         address = 4'd1;
         #1;
         if (readdata[0] === 1'b0) begin
            idle_at = k;
            break;
         end
         if (k <= 12) begin
            expect_sig(K_TONE, 32'((k / 3) % 2), "t1_tone_wave");
            expect_sig(K_RD, 32'd1, "t1_status_busy");
         end
      end
      expect_range(32'(idle_at), 31, 40, "t1_idle_cycle");
      expect_sig(K_TONE, 32'd0, "t1_tone_idle");
      expect_sig(K_RD, 32'd0, "t1_status_idle");
      step(1);
      check_rd(4'd5, 32'd0, "t1_remain_end");

      // Legacy mode overrides the mixer; clearing it returns to tone output
      bus_write(4'd0, 32'd3);
      bus_write(4'd2, 32'd1);
      bus_write(4'd5, 32'd100);
      for (int k = 0; k < 8; k++) begin
         expect_sig(K_SPK, 32'd1, "t2_legacy_spk");
         expect_sig(K_TONE, 32'((k / 3) % 2), "t2_legacy_tone");
         step(1);
      end
      bus_write(4'd0, 32'd1);
      for (int k = 9; k <= 20; k++) begin
         expect_sig(K_SPK, 32'((k / 3) % 2), "t2_mixed_spk");
         expect_sig(K_TONE, 32'((k / 3) % 2), "t2_mixed_tone");
         step(1);
      end
      bus_write(4'd5, 32'd0);
      address = 4'd1;
      expect_sig(K_RD, 32'd0, "t2_stop_status");
      expect_sig(K_TONE, 32'd0, "t2_stop_tone");
      step(1);

      // Rest on channel 1: busy for two ticks, silent throughout
      bus_write(4'd6, 32'd0);
      bus_write(4'd7, 32'd2);
      address = 4'd1;
      expect_sig(K_RD, 32'd2, "t3_status_start");
      idle_at = 0;
      for (int k = 1; k <= 40; k++) begin
         step(1);
         address = 4'd1;
         #1;
         if (readdata[1] === 1'b0) begin
            idle_at = k;
            break;
         end
         expect_sig(K_TONE, 32'd0, "t3_rest_silent");
      end
      expect_range(32'(idle_at), 11, 20, "t3_idle_cycle");
      expect_sig(K_RD, 32'd0, "t3_status_idle");
      step(1);

      // Continuous tone holds past 100 ticks; zero duration stops it
      bus_write(4'd5, 32'h0000_FFFF);
      step(1100);
      check_rd(4'd1, 32'd1, "t4_still_busy");
      check_rd(4'd5, 32'h0000_FFFF, "t4_remain_held");
      bus_write(4'd5, 32'd0);
      address = 4'd1;
      expect_sig(K_RD, 32'd0, "t4_stop_status");
      expect_sig(K_TONE, 32'd0, "t4_stop_tone");
      step(1);

      // Disabling mid-note silences everything and blocks new notes
      bus_write(4'd6, 32'd5);
      bus_write(4'd5, 32'd50);
      bus_write(4'd7, 32'd50);
      step(4);
      check_rd(4'd1, 32'd3, "t5_both_busy");
      bus_write(4'd0, 32'd0);
      address = 4'd1;
      expect_sig(K_RD, 32'd0, "t5_disable_status");
      expect_sig(K_TONE, 32'd0, "t5_disable_tone");
      expect_sig(K_SPK, 32'd0, "t5_disable_spk");
      step(1);
      bus_write(4'd5, 32'd5);
      address = 4'd1;
      expect_sig(K_RD, 32'd0, "t5_write_ignored");
      step(3);
      expect_sig(K_TONE, 32'd0, "t5_tone_quiet");
      check_rd(4'd1, 32'd0, "t5_still_idle");
      bus_write(4'd0, 32'd1);
      bus_write(4'd5, 32'd5);
      address = 4'd1;
      expect_sig(K_RD, 32'd1, "t5_reenabled");
      step(1);

`ifdef SPEAKER_TONE_IRQ_EN
      // Interrupt on natural end of note, one cycle behind PENDING
      bus_write(4'd5, 32'd0);
      bus_write(4'd3, 32'h0000_3F00);
      bus_write(4'd3, 32'd1);
      expect_sig(K_IRQ, 32'd0, "irq_idle");
      check_rd(4'd3, 32'd1, "irq_mask_only");
      bus_write(4'd5, 32'd1);
      wait_idle(32'd1, 30, idle_at);
      expect_range(32'(idle_at), 1, 10, "irq_note_end");
      expect_sig(K_IRQ, 32'd0, "irq_lag");
      step(1);
      expect_sig(K_IRQ, 32'd1, "irq_asserted");
      check_rd(4'd3, 32'h0000_0101, "irq_pending_set");
      bus_write(4'd3, 32'h0000_0101);
      step(1);
      expect_sig(K_IRQ, 32'd0, "irq_cleared");
      check_rd(4'd3, 32'd1, "irq_pending_clear");
`endif

      // Asynchronous reset in the middle of a note
      bus_write(4'd4, 32'd3);
      bus_write(4'd0, 32'd1);
      bus_write(4'd5, 32'd20);
      step(3);
      expect_sig(K_TONE, 32'd1, "pre_reset_tone");
      step(1);
      reset_n = 1'b0;
      #1;
      address = 4'd1;
      expect_sig(K_TONE, 32'd0, "reset_tone");
      expect_sig(K_SPK, 32'd0, "reset_spk");
      expect_sig(K_RD, 32'd0, "reset_status");
      step(1);
      reset_n = 1'b1;
      check_rd(4'd0, 32'd0, "reset_control");
      check_rd(4'd4, 32'd0, "reset_divider0");

      step(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
